// File: rtl/pe_array_feeder.sv
// Skews activation rows diagonally into the systolic array, stalls it on upstream bubbles and flushes zeros to drain it.
// A row accepted in cycle t reaches ins[i] in cycle t+1+i; in_ready is high only while feeding.
module pe_array_feeder #(
  parameter int ARRAY_SIZE         = 2,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ROW_CNT_WIDTH      = 8,
  parameter int FLUSH_CYCLES       = 2*ARRAY_SIZE-1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_CNT_WIDTH-1:0]      num_rows,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COMPUTE_DATA_WIDTH-1:0] in_row [ARRAY_SIZE],
  output logic [COMPUTE_DATA_WIDTH-1:0] ins [ARRAY_SIZE],
  output logic                          compute,
  output logic                          busy,
  output logic                          done
);

  localparam int FCW = $clog2(FLUSH_CYCLES+1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     shift;
  logic [ROW_CNT_WIDTH-1:0] row_cnt;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q;
  logic [FCW-1:0]           flush_cnt;

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_rows == '0) ? DONE : FEED;
      end
      FEED: begin
        shift = in_valid;
        if (in_valid && (row_cnt + ROW_CNT_WIDTH'(1) == num_rows_q)) state_nxt = FLUSH;
      end
      FLUSH: begin
        shift = 1'b1;
        if (flush_cnt == FCW'(FLUSH_CYCLES-1)) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      compute    <= 1'b0;
      row_cnt    <= '0;
      num_rows_q <= '0;
      flush_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      compute <= shift;
      if (state == IDLE && start) begin
        row_cnt    <= '0;
        num_rows_q <= num_rows;
        flush_cnt  <= '0;
      end else if (state == FEED && in_valid) begin
        row_cnt <= row_cnt + ROW_CNT_WIDTH'(1);
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + FCW'(1);
      end
    end
  end

  // Lane i is i+1 stages deep; every lane holds on a stall so the wavefront stays aligned.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [COMPUTE_DATA_WIDTH-1:0] sr [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) sr[j] <= '0;
      end else if (shift) begin
        sr[0] <= (state == FEED) ? in_row[i] : '0;
        for (int j = 1; j <= i; j++) sr[j] <= sr[j-1];
      end
    end

    assign ins[i] = sr[i];
  end

  assign in_ready = (state == FEED);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomized and directed bench for pe_array_feeder, checked every cycle against a stream-based model.
module tb_pe_array_feeder;
  localparam int A  = 2;
  localparam int W  = 4;
  localparam int RW = 8;
  localparam int F  = 2*A-1;
  localparam int M_IDLE = 0, M_FEED = 1, M_FLUSH = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] num_rows;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_row [A];
  logic [W-1:0]  ins [A];
  logic          compute;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  pe_array_feeder #(.ARRAY_SIZE(A), .COMPUTE_DATA_WIDTH(W), .ROW_CNT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .ins(ins), .compute(compute), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: every shift appends one row (real or zero) to a stream; ins[i] is the entry i shifts back.
  int             m_mode = M_IDLE;
  int             m_rows_left = 0;
  int             m_flush_left = 0;
  logic           m_comp = 1'b0;
  bit             chk_en = 1'b0;
  logic [A*W-1:0] stream [$];

  always @(posedge clk) begin
    logic [A*W-1:0] r;
    bit sh;
    if (rst) begin
      m_mode = M_IDLE;
      m_comp = 1'b0;
      stream.delete();
      chk_en = 1'b1;
    end else begin
      sh = (m_mode == M_FEED && in_valid) || (m_mode == M_FLUSH);
      m_comp = sh;
      if (sh) begin
        r = '0;
        if (m_mode == M_FEED) for (int i = 0; i < A; i++) r[i*W +: W] = in_row[i];
        stream.push_back(r);
      end
      case (m_mode)
        M_IDLE: if (start) begin
          if (num_rows == 0) m_mode = M_DONE;
          else begin m_mode = M_FEED; m_rows_left = int'(num_rows); end
        end
        M_FEED: if (in_valid) begin
          m_rows_left--;
          if (m_rows_left == 0) begin m_mode = M_FLUSH; m_flush_left = F; end
        end
        M_FLUSH: begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = M_DONE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic [W-1:0] exp_ins(input int i);
    int idx;
    idx = stream.size() - 1 - i;
    return (idx >= 0) ? stream[idx][i*W +: W] : '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_mode == M_FEED);
      chk("busy", busy, m_mode != M_IDLE);
      chk("done", done, m_mode == M_DONE);
      chk("compute", compute, m_comp);
      for (int i = 0; i < A; i++) chk($sformatf("ins[%0d]", i), ins[i], exp_ins(i));
    end
  end

  // Directed job over a 9-cycle window; cycle 0 is the cycle in which start is sampled.
  task automatic run_job(input int num, input logic [8:0] vmask, input int s2, input int rc,
                         output logic [8:0][3:0] i0, output logic [8:0][3:0] i1,
                         output logic [8:0] cm, output logic [8:0] dn,
                         output logic [8:0] rd, output logic [8:0] bz);
    int ridx;
    ridx = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      i0[c] = ins[0];
      i1[c] = ins[1];
      cm[c] = compute;
      dn[c] = done;
      rd[c] = in_ready;
      bz[c] = busy;
      if (c >= 2 && vmask[c-1] && ridx < 3) ridx++;
      rst       = (c == rc);
      start     = (c == 0) || (c == s2);
      num_rows  = (c == 0) ? RW'(num) : ((c == s2) ? RW'(5) : RW'(0));
      in_valid  = vmask[c];
      in_row[0] = W'(2*ridx + 1);
      in_row[1] = W'(2*ridx + 2);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    logic [8:0][3:0] i0, i1;
    logic [8:0] cm, dn, rd, bz;
    run_job(2, 9'b000000111, -1, -1, i0, i1, cm, dn, rd, bz);
    chk({tag, "_ins0"}, i0, 36'h000003100);
    chk({tag, "_ins1"}, i1, 36'h000042000);
    chk({tag, "_compute"}, cm, 9'b001111100);
    chk({tag, "_done"}, dn, 9'b001000000);
    chk({tag, "_busy"}, bz, 9'b001111110);
  endtask

  initial begin
    logic [8:0][3:0] i0, i1;
    logic [8:0] cm, dn, rd, bz;
    int accepted;

    rst = 1'b1; start = 1'b1; num_rows = 8'd3; in_valid = 1'b1;
    in_row[0] = 4'h7; in_row[1] = 4'h9;
    repeat (2) begin
      @(negedge clk);
      start = 1'($urandom); num_rows = RW'($urandom); in_valid = 1'($urandom);
      in_row[0] = W'($urandom); in_row[1] = W'($urandom);
    end
    chk("rst_outputs", {in_ready, busy, done, compute}, 4'b0000);
    chk("rst_ins", {ins[1], ins[0]}, 8'h00);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; num_rows = '0;

    check_basic("basic");

    run_job(2, 9'b000001011, -1, -1, i0, i1, cm, dn, rd, bz);
    chk("stall_ins0", i0, 36'h000031100);
    chk("stall_ins1", i1, 36'h000420000);
    chk("stall_c3_compute", cm[3], 1'b0);
    chk("stall_compute", cm, 9'b011110100);
    chk("stall_done", dn, 9'b010000000);

    run_job(0, 9'b000000000, -1, -1, i0, i1, cm, dn, rd, bz);
    chk("zero_done", dn, 9'b000000010);
    chk("zero_compute", cm, 9'b000000000);
    chk("zero_ready", rd, 9'b000000000);
    chk("zero_ins", {i1, i0}, 72'h0);

    run_job(3, 9'b000001111, 2, -1, i0, i1, cm, dn, rd, bz);
    accepted = 0;
    for (int c = 0; c < 9; c++) if (rd[c]) accepted++;
    chk("ign_handshakes", accepted, 3);
    chk("ign_ready", rd, 9'b000001110);
    chk("ign_done", dn, 9'b010000000);
    chk("ign_compute", cm, 9'b011111100);

    run_job(4, 9'b000001111, -1, 3, i0, i1, cm, dn, rd, bz);
    chk("mrst_ready_before", rd[3], 1'b1);
    chk("mrst_after", {i1[4], i0[4], cm[4], bz[4], rd[4]}, 11'h000);
    chk("mrst_no_done", dn, 9'b000000000);

    check_basic("rebasic");

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      num_rows  = RW'($urandom_range(0, 6));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_row[0] = W'($urandom);
      in_row[1] = W'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
